// File: rtl/tdp_be_pkg.sv
// Shared sizing helpers and request layout for the tdp_be dual-port buffer.
// Request word is packed MSB->LSB as {we, be, wdata, addr}.
package tdp_be_pkg;

  localparam int ADDR_LSB   = 0;
  localparam int DEF_W_DATA = 32;
  localparam int DEF_W_LANE = 8;
  localparam int DEF_W_ADDR = 10;
  localparam int DEF_NB     = DEF_W_DATA / DEF_W_LANE;

  function automatic int nb_f(input int w_data, input int w_lane);
    return w_data / w_lane;
  endfunction

  function automatic int req_w_f(input int w_data, input int w_lane, input int w_addr);
    return 1 + nb_f(w_data, w_lane) + w_data + w_addr;
  endfunction

  function automatic int wdata_lsb(input int w_addr);
    return w_addr;
  endfunction

  function automatic int be_lsb(input int w_data, input int w_addr);
    return w_addr + w_data;
  endfunction

  function automatic int we_bit(input int w_data, input int w_lane, input int w_addr);
    return w_addr + w_data + nb_f(w_data, w_lane);
  endfunction

  typedef struct packed {
    logic                  we;
    logic [DEF_NB-1:0]     be;
    logic [DEF_W_DATA-1:0] wdata;
    logic [DEF_W_ADDR-1:0] addr;
  } req_def_t;

endpackage

// File: rtl/tdp_be_port.sv
// One port of tdp_be: request unpack, read credit counter, read pipeline
// valid tracking and a fall-through read-data FIFO.
module tdp_be_port import tdp_be_pkg::*; #(
  parameter int W_DATA = 32,
  parameter int W_LANE = 8,
  parameter int W_ADDR = 10,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_req_valid,
  output logic                                   o_req_ready,
  input  logic [req_w_f(W_DATA,W_LANE,W_ADDR)-1:0] i_req_data,
  input  logic [W_DATA-1:0]                      i_mem_rdata,
  output logic                                   o_mem_wr,
  output logic [W_ADDR-1:0]                      o_mem_addr,
  output logic [W_DATA-1:0]                      o_mem_wdata,
  output logic [nb_f(W_DATA,W_LANE)-1:0]         o_mem_be,
  output logic                                   o_mem_inr,
  output logic                                   o_dout_valid,
  input  logic                                   i_dout_ready,
  output logic [W_DATA-1:0]                      o_dout_data
);

  localparam int NB  = nb_f(W_DATA, W_LANE);
  localparam int CAP = RD_LAT + 1;
  localparam int CW  = $clog2(CAP + 1);
  localparam int PW  = $clog2(CAP);

  logic              w_we;
  logic              w_acc;
  logic              w_rd_acc;
  logic              w_dout_hs;
  logic              w_arrive;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     r_occ;
  logic [CW-1:0]     r_fcnt;
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [RD_LAT-1:0] r_pv;
  logic [W_DATA-1:0] r_fifo [CAP];

  assign w_we        = i_req_data[we_bit(W_DATA, W_LANE, W_ADDR)];
  assign o_mem_be    = i_req_data[be_lsb(W_DATA, W_ADDR) +: NB];
  assign o_mem_wdata = i_req_data[wdata_lsb(W_ADDR) +: W_DATA];
  assign o_mem_addr  = i_req_data[ADDR_LSB +: W_ADDR];
  assign o_mem_inr   = (int'(o_mem_addr) < DEPTH);

  assign w_arrive     = r_pv[RD_LAT-1];
  assign w_fifo_empty = (r_fcnt == '0);
  assign o_dout_valid = !w_fifo_empty || w_arrive;
  assign w_dout_hs    = o_dout_valid && i_dout_ready;

  // A freed credit may be reused in the same cycle it is released downstream.
  assign o_req_ready = w_we || (r_occ < CW'(CAP)) || w_dout_hs;
  assign w_acc       = i_req_valid && o_req_ready;
  assign w_rd_acc    = w_acc && !w_we;
  assign o_mem_wr    = w_acc && w_we && o_mem_inr;

  assign w_push = w_arrive && !(w_fifo_empty && i_dout_ready);
  assign w_pop  = w_dout_hs && !w_fifo_empty;

  assign o_dout_data = !w_fifo_empty ? r_fifo[r_rp] :
                       w_arrive      ? i_mem_rdata  : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ  <= '0;
      r_pv   <= '0;
      r_fcnt <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
    end else begin
      if (w_rd_acc && !w_dout_hs)
        r_occ <= r_occ + 1'b1;
      else if (!w_rd_acc && w_dout_hs)
        r_occ <= r_occ - 1'b1;
      r_pv <= (r_pv << 1) | RD_LAT'(w_rd_acc);
      if (w_push)
        r_wp <= (r_wp == PW'(CAP - 1)) ? '0 : r_wp + 1'b1;
      if (w_pop)
        r_rp <= (r_rp == PW'(CAP - 1)) ? '0 : r_rp + 1'b1;
      if (w_push && !w_pop)
        r_fcnt <= r_fcnt + 1'b1;
      else if (w_pop && !w_push)
        r_fcnt <= r_fcnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_fifo[r_wp] <= i_mem_rdata;
  end

endmodule

// File: rtl/tdp_be.sv
// True-dual-port RAM with per-lane write enables, valid/ready request and
// read-data channels per port, read-first cross-port collision behaviour.
module tdp_be import tdp_be_pkg::*; #(
  parameter int W_DATA = 32,
  parameter int W_LANE = 8,
  parameter int W_ADDR = 10,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_req0_valid,
  output logic                                   o_req0_ready,
  input  logic [req_w_f(W_DATA,W_LANE,W_ADDR)-1:0] i_req0_data,
  output logic                                   o_dout0_valid,
  input  logic                                   i_dout0_ready,
  output logic [W_DATA-1:0]                      o_dout0_data,
  input  logic                                   i_req1_valid,
  output logic                                   o_req1_ready,
  input  logic [req_w_f(W_DATA,W_LANE,W_ADDR)-1:0] i_req1_data,
  output logic                                   o_dout1_valid,
  input  logic                                   i_dout1_ready,
  output logic [W_DATA-1:0]                      o_dout1_data
);

  localparam int NB = nb_f(W_DATA, W_LANE);

  logic [1:0]                        w_wr;
  logic [1:0]                        w_inr;
  logic [1:0][W_ADDR-1:0]            w_addr;
  logic [1:0][W_DATA-1:0]            w_wdata;
  logic [1:0][NB-1:0]                w_be;
  logic [1:0][W_DATA-1:0]            r_rd_s1;
  logic [1:0][W_DATA-1:0]            w_rdata;
  logic [NB-1:0][W_LANE-1:0]         r_mem [DEPTH];

  tdp_be_port #(
    .W_DATA(W_DATA), .W_LANE(W_LANE), .W_ADDR(W_ADDR), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) u_port0 (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req0_valid),
    .o_req_ready  (o_req0_ready),
    .i_req_data   (i_req0_data),
    .i_mem_rdata  (w_rdata[0]),
    .o_mem_wr     (w_wr[0]),
    .o_mem_addr   (w_addr[0]),
    .o_mem_wdata  (w_wdata[0]),
    .o_mem_be     (w_be[0]),
    .o_mem_inr    (w_inr[0]),
    .o_dout_valid (o_dout0_valid),
    .i_dout_ready (i_dout0_ready),
    .o_dout_data  (o_dout0_data)
  );

  tdp_be_port #(
    .W_DATA(W_DATA), .W_LANE(W_LANE), .W_ADDR(W_ADDR), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) u_port1 (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req1_valid),
    .o_req_ready  (o_req1_ready),
    .i_req_data   (i_req1_data),
    .i_mem_rdata  (w_rdata[1]),
    .o_mem_wr     (w_wr[1]),
    .o_mem_addr   (w_addr[1]),
    .o_mem_wdata  (w_wdata[1]),
    .o_mem_be     (w_be[1]),
    .o_mem_inr    (w_inr[1]),
    .o_dout_valid (o_dout1_valid),
    .i_dout_ready (i_dout1_ready),
    .o_dout_data  (o_dout1_data)
  );

  // Port 0 owns any lane both ports write to the same word in one cycle.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NB; i++) begin
      if (w_wr[0] && w_be[0][i])
        r_mem[w_addr[0]][i] <= w_wdata[0][i*W_LANE +: W_LANE];
      if (w_wr[1] && w_be[1][i] && !(w_wr[0] && w_be[0][i] && (w_addr[0] == w_addr[1])))
        r_mem[w_addr[1]][i] <= w_wdata[1][i*W_LANE +: W_LANE];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int p = 0; p < 2; p++)
      r_rd_s1[p] <= w_inr[p] ? r_mem[w_addr[p]] : '0;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [1:0][W_DATA-1:0] r_rd_s2;
      always_ff @(posedge i_clk) r_rd_s2 <= r_rd_s1;
      assign w_rdata = r_rd_s2;
    end else begin : g_lat1
      assign w_rdata = r_rd_s1;
    end
  endgenerate

endmodule
